// File: rtl/cpu_seq.sv
// cpu_seq: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the CPU core.
// Owns pc, ir and zf, and turns the decoder's write enables into one-cycle
// strobes. The instruction and data memories use ready/ack handshakes, so
// they may take any number of wait cycles.
// Optional feature macro: CPU_SEQ_PERF_EN adds the cyc_cnt/ret_cnt
// saturating performance counters.
module cpu_seq #(
    parameter int              AW       = 9,
    parameter int              IW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              CW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] ir,
    output logic [AW-1:0] pc,
    output logic          zf,
    input  logic          alu_zf,
    input  logic          dec_pc_we,
    input  logic [AW-1:0] dec_pc_in,
    input  logic          dec_reg_we,
    input  logic          dec_mem_we,
    input  logic          dec_mem_rd,
    input  logic          dec_halt,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_ack,
    output logic          reg_we,
`ifdef CPU_SEQ_PERF_EN
    output logic [CW-1:0] cyc_cnt,
    output logic [CW-1:0] ret_cnt,
`endif
    output logic [2:0]    state,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_inc;
    logic [IW-1:0] ir_q;
    logic          zf_q;
    logic          is_store;

    // PC increment wraps modulo 2^AW by construction.
    assign pc_inc   = pc_q + {{(AW-1){1'b0}}, 1'b1};
    assign is_store = dec_mem_we & ~dec_mem_rd;

    // State register; reset forces IDLE so every strobe drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acks and start are only honoured in their own states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_mem_we || dec_mem_rd) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM:    if (dmem_ack) state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   if (start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // PC, instruction register and zero flag; ir and zf stay frozen from
    // DECODE through WB so the decoder outputs remain stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            ir_q <= '0;
            zf_q <= 1'b0;
        end else begin
            if (state_q == S_FETCH && imem_ack) begin
                ir_q <= imem_rdata;
            end
            if (state_q == S_EXEC) begin
                zf_q <= alu_zf;
                if (dec_halt) begin
                    pc_q <= pc_inc;
                end
            end
            if (state_q == S_WB) begin
                pc_q <= dec_pc_we ? dec_pc_in : pc_inc;
            end
        end
    end

    // Strobes are decoded from the registered state (plus the stable decoder
    // outputs), never from an ack, so they cannot glitch on handshakes.
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = (state_q == S_MEM) & dec_mem_we;
    assign reg_we    = (state_q == S_WB) & dec_reg_we & ~is_store;
    assign halted    = (state_q == S_HALT);
    assign state     = state_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign zf        = zf_q;

`ifdef CPU_SEQ_PERF_EN
    logic [CW-1:0] cyc_q;
    logic [CW-1:0] ret_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    // Busy-cycle and retired-instruction counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) begin
                cyc_q <= sat_inc(cyc_q);
            end
            if (state_q == S_WB || (state_q == S_EXEC && dec_halt)) begin
                ret_q <= sat_inc(ret_q);
            end
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed bench for cpu_seq. The bench plays the part of the
// memories and the decoder; expected fetch addresses, write-back strobes and
// next-pc values are queued when an instruction is issued and popped when
// the sequencer reaches the matching state.
module tb_cpu_seq;

    localparam int AW = 9;
    localparam int IW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] ir;
    logic [AW-1:0] pc;
    logic          zf;
    logic          alu_zf;
    logic          dec_pc_we;
    logic [AW-1:0] dec_pc_in;
    logic          dec_reg_we;
    logic          dec_mem_we;
    logic          dec_mem_rd;
    logic          dec_halt;
    logic          dmem_req;
    logic          dmem_we;
    logic          dmem_ack;
    logic          reg_we;
    logic [2:0]    state;
    logic          halted;
`ifdef CPU_SEQ_PERF_EN
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] ret_cnt;
`endif

    cpu_seq #(.AW(AW), .IW(IW), .RESET_PC(9'h000), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .pc         (pc),
        .zf         (zf),
        .alu_zf     (alu_zf),
        .dec_pc_we  (dec_pc_we),
        .dec_pc_in  (dec_pc_in),
        .dec_reg_we (dec_reg_we),
        .dec_mem_we (dec_mem_we),
        .dec_mem_rd (dec_mem_rd),
        .dec_halt   (dec_halt),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .reg_we     (reg_we),
`ifdef CPU_SEQ_PERF_EN
        .cyc_cnt    (cyc_cnt),
        .ret_cnt    (ret_cnt),
`endif
        .state      (state),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] sb_addr[$];
    logic [AW-1:0] sb_pc[$];
    logic          sb_reg[$];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction starting from a cycle in which the DUT is in FETCH.
    task automatic do_instr(input logic [AW-1:0] exp_pc, input logic [IW-1:0] iw,
                            input int iwait, input int dwait,
                            input logic reg_we_d, input logic mem_we_d,
                            input logic mem_rd_d, input logic halt_d,
                            input logic pc_we_d, input logic [AW-1:0] target,
                            input logic azf);
        logic          is_mem;
        logic [AW-1:0] exp_next;
        int            exp_cyc;
        int            cyc;
        int            dcnt;
        is_mem   = !halt_d && (mem_we_d || mem_rd_d);
        exp_next = (!halt_d && pc_we_d) ? target : exp_pc + 9'd1;
        exp_cyc  = halt_d ? iwait + 3 : iwait + 4 + (is_mem ? dwait + 1 : 0);
        sb_addr.push_back(exp_pc);
        sb_pc.push_back(exp_next);
        sb_reg.push_back(reg_we_d & ~(mem_we_d & ~mem_rd_d));
        cyc = 0;
        chk("fetch_state", 32'(state), 32'd1);
        for (int i = 0; i < iwait; i++) begin
            dmem_ack = 1'b1;
            start    = 1'b1;
            step();
            cyc++;
            dmem_ack = 1'b0;
            start    = 1'b0;
            chk("fetch_wait_req", 32'(imem_req), 32'd1);
        end
        chk("imem_addr", 32'(imem_addr), 32'(sb_addr.pop_front()));
        imem_ack   = 1'b1;
        imem_rdata = iw;
        dec_reg_we = reg_we_d;
        dec_mem_we = mem_we_d;
        dec_mem_rd = mem_rd_d;
        dec_halt   = halt_d;
        dec_pc_we  = pc_we_d;
        dec_pc_in  = target;
        alu_zf     = azf;
        step();
        cyc++;
        imem_ack = 1'b0;
        chk("decode_state", 32'(state), 32'd2);
        chk("ir", ir, iw);
        step();
        cyc++;
        chk("exec_state", 32'(state), 32'd3);
        step();
        cyc++;
        chk("zf", 32'(zf), 32'(azf));
        if (halt_d) begin
            chk("halt_state", 32'(state), 32'd6);
            chk("halt_pc", 32'(pc), 32'(sb_pc.pop_front()));
            void'(sb_reg.pop_front());
        end else begin
            if (is_mem) begin
                dcnt = 0;
                while (dcnt <= dwait) begin
                    chk("dmem_req", 32'(dmem_req), 32'd1);
                    chk("dmem_we", 32'(dmem_we), 32'(mem_we_d));
                    chk("mem_reg_we", 32'(reg_we), 32'd0);
                    if (dcnt == dwait) dmem_ack = 1'b1;
                    step();
                    cyc++;
                    dmem_ack = 1'b0;
                    dcnt++;
                end
            end
            chk("wb_state", 32'(state), 32'd5);
            chk("reg_we", 32'(reg_we), 32'(sb_reg.pop_front()));
            step();
            cyc++;
            chk("next_fetch_state", 32'(state), 32'd1);
            chk("reg_we_single", 32'(reg_we), 32'd0);
            chk("next_pc", 32'(pc), 32'(sb_pc.pop_front()));
        end
        chk("cycles", 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        alu_zf     = 1'b0;
        dec_pc_we  = 1'b0;
        dec_pc_in  = '0;
        dec_reg_we = 1'b0;
        dec_mem_we = 1'b0;
        dec_mem_rd = 1'b0;
        dec_halt   = 1'b0;
        dmem_ack   = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_zf", 32'(zf), 32'd0);
        chk("rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, reg_we}, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        step();
        chk("idle_ack_ignored", 32'(state), 32'd0);
        imem_ack = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;

        // Three ALU ops with zero-wait memory, then a non-writing op at pc 3.
        do_instr(9'd0, 32'hA000_0000, 0, 0, 1, 0, 0, 0, 0, 9'd0, 1);
        do_instr(9'd1, 32'hA000_0001, 0, 0, 1, 0, 0, 0, 0, 9'd0, 0);
        do_instr(9'd2, 32'hA000_0002, 0, 0, 1, 0, 0, 0, 0, 9'd0, 1);
        chk("pc_after_three", 32'(pc), 32'd3);
`ifdef CPU_SEQ_PERF_EN
        chk("cyc_cnt_12", cyc_cnt, 32'd12);
        chk("ret_cnt_3", ret_cnt, 32'd3);
`endif
        do_instr(9'd3, 32'hA000_0003, 0, 0, 0, 0, 0, 0, 0, 9'd0, 0);

        // Load with three dmem wait cycles, store with imem and dmem waits.
        do_instr(9'd4, 32'hB000_0004, 0, 3, 1, 0, 1, 0, 0, 9'd0, 0);
        do_instr(9'd5, 32'hC000_0005, 2, 1, 1, 1, 0, 0, 0, 9'd0, 1);
        do_instr(9'd6, 32'hA000_0006, 0, 0, 1, 0, 0, 0, 0, 9'd0, 0);

        // Halt at pc 7; acks and strobes must stay dead while halted.
        do_instr(9'd7, 32'hF000_0007, 0, 0, 1, 1, 0, 1, 0, 9'd0, 1);
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            dmem_ack = ~i[0];
            step();
            chk("halt_strobes", {27'd0, halted, imem_req, dmem_req, dmem_we, reg_we}, 32'h10);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd8);

        // Branches around the top of the address space, then wrap.
        do_instr(9'd8,   32'hD000_0008, 0, 0, 0, 0, 0, 0, 1, 9'h1FF, 0);
        do_instr(9'h1FF, 32'hD000_01FF, 1, 0, 0, 0, 0, 0, 1, 9'h1F0, 0);
        chk("branch_addr", 32'(imem_addr), 32'h1F0);
        do_instr(9'h1F0, 32'hD000_01F0, 0, 0, 0, 0, 0, 0, 1, 9'h1FF, 1);
        do_instr(9'h1FF, 32'hA000_01FF, 0, 0, 1, 0, 0, 0, 0, 9'd0, 0);
        chk("wrap_addr", 32'(imem_addr), 32'h000);
        do_instr(9'd0, 32'hA000_0010, 0, 0, 1, 0, 0, 0, 0, 9'd0, 1);
        do_instr(9'd1, 32'hD000_0001, 0, 0, 0, 0, 0, 0, 1, 9'd1, 0);
        chk("self_loop_addr", 32'(imem_addr), 32'd1);

        // Reset asserted during a fetch wait aborts at once.
        step();
        step();
        chk("pre_rst_fetch", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_pc", 32'(pc), 32'd0);
        chk("async_rst_imem_req", 32'(imem_req), 32'd0);
        chk("async_rst_ir", ir, 32'd0);
`ifdef CPU_SEQ_PERF_EN
        chk("rst_cyc_cnt", cyc_cnt, 32'd0);
        chk("rst_ret_cnt", ret_cnt, 32'd0);
`endif
        step();
        chk("rst_hold_strobes", {28'd0, imem_req, dmem_req, dmem_we, reg_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Parametrised multicycle sequencer for the next-generation CPU core.
- Replaces the single-cycle "every unit fires every clock" scheme with a FETCH/DECODE/EXEC/MEM/WB state machine.
- Owns the PC, instruction register and zero flag, and gates the decoder's write enables into single-cycle strobes.
- Uses ready/ack handshakes so instruction and data memories may have variable latency.

Parameters:
- AW, 9, PC / instruction address width.
- IW, 32, instruction width.
- RESET_PC, 0, PC value after reset (AW bits).
- CW, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leaves IDLE or HALT.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address; always equals pc.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  IW  fetched instruction.
- ir  out  IW  instruction register, feeds the decoder.
- pc  out  AW  current PC.
- zf  out  1  registered zero flag, feeds the decoder.
- alu_zf  in  1  combinational ALU zero output.
- dec_pc_we  in  1  decoder: take branch target.
- dec_pc_in  in  AW  decoder: branch target.
- dec_reg_we  in  1  decoder: instruction writes the register file.
- dec_mem_we  in  1  decoder: store.
- dec_mem_rd  in  1  decoder: load (write-back mux selects memory).
- dec_halt  in  1  decoder: halt instruction.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier; valid only while dmem_req=1.
- dmem_ack  in  1  data access complete.
- reg_we  out  1  register-file write strobe.
- state  out  3  encoded state, for debug.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, zf=0. All strobes (imem_req, dmem_req, dmem_we, reg_we) are 0, and halted=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: outputs idle. Moves to FETCH on start=1.
- FETCH:
  - imem_req=1 with imem_addr=pc, held stable until imem_ack.
  - On imem_ack: ir<=imem_rdata, then go to DECODE. Minimum 1 cycle; no limit on wait cycles.
- DECODE: one cycle; the decoder settles from ir. No strobes.
- EXEC (one cycle):
  - zf<=alu_zf, every instruction.
  - If dec_halt: go to HALT, with pc<=pc+1. No reg or mem write.
  - Else if dec_mem_we or dec_mem_rd: go to MEM.
  - Else: go to WB.
- MEM:
  - dmem_req=1, dmem_we=dec_mem_we, held until dmem_ack.
  - On ack: if dec_mem_rd go to WB; otherwise (store) go to WB with reg_we suppressed.
- WB (one cycle):
  - reg_we=dec_reg_we & ~(dec_mem_we & ~dec_mem_rd).
  - pc<=dec_pc_we ? dec_pc_in : pc+1.
  - Go to FETCH.
- PC arithmetic is modulo 2^AW: pc=2^AW-1 increments to 0. A branch to the current pc is legal (self-loop).
- CPI: 4 for ALU ops; 5 + extra wait cycles for memory ops (imem and dmem waits add 1 each).
- The decoder's inputs must remain stable from DECODE through WB. The block relies on ir and zf not changing in that window; zf changes only on the EXEC edge.
- HALT: halted=1, all strobes 0. Moves to FETCH on start=1, resuming at the saved pc (halt address+1).
- Acks arriving outside their wait state are ignored. start is ignored outside IDLE and HALT.
- rst_n asserted mid-access (e.g. during FETCH or MEM) aborts immediately; no strobe may glitch high after reset assertion.
- All outputs are registered or decoded from state only. No combinational path from imem_ack or dmem_ack to any strobe.

Optional Feature:
- Macro: CPU_SEQ_PERF_EN.
- When defined:
  - Adds outputs cyc_cnt[CW] and ret_cnt[CW], both reset to 0.
  - cyc_cnt increments every cycle while state is not IDLE or HALT.
  - ret_cnt increments on each WB cycle and on each EXEC to HALT transition.
  - Both saturate at all-ones.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then start pulse, zero-wait memories, 3 ALU ops at pc 0..2:
  - FETCH asserted at cycles 1, 5, 9.
  - reg_we pulses once per instruction; pc=3 after the third WB.
- Load at pc=4 with dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles with dmem_we=0, then one reg_we pulse.
  - Instruction takes 8 cycles total.
- Store: dmem_we=1 for the whole MEM state; reg_we stays 0; pc advances by 1.
- Branch with dec_pc_we=1, dec_pc_in=0x1F0 from pc=0x1FF; then non-branch at pc=0x1FF (AW=9):
  - Branch case: next imem_addr=0x1F0.
  - Non-branch case: pc wraps to 0x000.
- Halt at pc=7: halted=1, strobes stay 0 for 20 cycles; start resumes fetch at imem_addr=8.
- rst_n pulsed low during a FETCH wait: state=IDLE, pc=RESET_PC, imem_req=0 immediately. With CPU_SEQ_PERF_EN, both counters read 0.
